// File: rtl/activation_window.sv
`default_nettype none
// ============================================================================
//  Module   : activation_window
//  Purpose  : ReLU + right-shift requantization + saturation of signed
//             convolution sums, buffering SIZE*SIZE window pixels per lane
//             and emitting one packed window word per completed window for
//             the max-pooling stage.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             in_valid       - OFM beat valid
//             clear          - abort a partially filled window
//             OFM            - NUM_POOLING signed OFM_BIT-wide lane sums
//             out_valid      - one-cycle pulse, ACTIVATION holds a window
//             ACTIVATION     - lane k, pixel j at [(k*SIZE*SIZE+j)*IFM_BIT]
//             sat            - some pixel of the emitted window saturated
//             busy           - window partially filled
//  Options  : ACT_ROUND_EN   - round-half-up before the shift (else truncate)
//  Revision : 1.0 - initial release
// ============================================================================
module activation_window #(
  parameter int OFM_BIT     = 29,
  parameter int IFM_BIT     = 8,
  parameter int SIZE        = 2,
  parameter int NUM_POOLING = 8,
  parameter int SHIFT       = 12
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  input  logic                                     clear,
  input  logic [NUM_POOLING*OFM_BIT-1:0]           OFM,
  output logic                                     out_valid,
  output logic [NUM_POOLING*SIZE*SIZE*IFM_BIT-1:0] ACTIVATION,
  output logic                                     sat,
  output logic                                     busy
);

  localparam int c_PIX = SIZE * SIZE;
  localparam int c_CW  = (c_PIX > 1) ? $clog2(c_PIX) : 1;
  localparam int c_AW  = NUM_POOLING * c_PIX * IFM_BIT;
  // One extra bit so the rounding add on a maximal positive sum cannot wrap.
  localparam int c_XW  = OFM_BIT + 1;

  localparam logic [c_CW-1:0]    c_LAST = c_CW'(c_PIX - 1);
  localparam logic [c_XW-1:0]    c_MAXV = c_XW'(2 ** (IFM_BIT - 1) - 1);
  localparam logic [IFM_BIT-1:0] c_PMAX = IFM_BIT'(2 ** (IFM_BIT - 1) - 1);
`ifdef ACT_ROUND_EN
  localparam logic [c_XW-1:0]    c_RND  = c_XW'(1) << (SHIFT - 1);
`endif

  logic [c_CW-1:0]        r_cnt;
  logic                   r_sticky;
  logic [c_AW-1:0]        r_buf;
  logic [c_AW-1:0]        r_act;
  logic                   r_valid;
  logic                   r_sat;

  logic [IFM_BIT-1:0]     w_pix [NUM_POOLING];
  logic [NUM_POOLING-1:0] w_lane_sat;
  logic [c_AW-1:0]        w_buf_next;
  logic                   w_accept;
  logic                   w_last;

  // --------------------------------------------------------------------------
  // Per-lane quantization, combinational on the incoming beat.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_POOLING; k++) begin : g_lane
    logic [OFM_BIT-1:0] w_x;
    logic [c_XW-1:0]    w_ext;
    logic [c_XW-1:0]    w_sum;
    logic [c_XW-1:0]    w_y;
    logic               w_neg;
    logic               w_ovf;

    assign w_x   = OFM[k*OFM_BIT +: OFM_BIT];
    assign w_neg = w_x[OFM_BIT-1];
    assign w_ext = {w_neg, w_x};
`ifdef ACT_ROUND_EN
    assign w_sum = w_ext + c_RND;
`else
    assign w_sum = w_ext;
`endif
    // Negative inputs are forced to zero below, so a logical shift is
    // sufficient for every value that reaches the output.
    assign w_y   = w_sum >> SHIFT;
    assign w_ovf = (w_y > c_MAXV);

    assign w_lane_sat[k] = ~w_neg & w_ovf;
    assign w_pix[k]      = w_neg ? '0 : (w_ovf ? c_PMAX : w_y[IFM_BIT-1:0]);
  end

  assign w_accept = in_valid & ~clear;
  assign w_last   = w_accept & (r_cnt == c_LAST);

  // Buffer image including the current beat; the final beat of a window is
  // taken from here so it bypasses the registered buffer.
  always_comb begin
    w_buf_next = r_buf;
    if (w_accept) begin
      for (int k = 0; k < NUM_POOLING; k++) begin
        w_buf_next[(k*c_PIX + int'(r_cnt))*IFM_BIT +: IFM_BIT] = w_pix[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_buf    <= '0;
      r_act    <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_valid <= w_last;
      r_sat   <= w_last & (r_sticky | (|w_lane_sat));

      if (w_last) begin
        r_act <= w_buf_next;
      end

      if (clear) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end

      if (clear || w_last) begin
        r_sticky <= 1'b0;
      end else if (w_accept) begin
        r_sticky <= r_sticky | (|w_lane_sat);
      end
    end
  end

  assign out_valid  = r_valid;
  assign ACTIVATION = r_act;
  assign sat        = r_sat;
  assign busy       = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_activation_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_activation_window
//  Purpose  : Scoreboard bench for activation_window. The driver feeds beats
//             and a window-level reference model pushes expected windows;
//             an independent monitor compares every DUT output cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_activation_window;

  localparam int OFM_BIT = 29;
  localparam int IFM_BIT = 8;
  localparam int SIZE    = 2;
  localparam int NP      = 8;
  localparam int SHIFT   = 12;
  localparam int PIX     = SIZE * SIZE;
  localparam int AW      = NP * PIX * IFM_BIT;
  localparam longint PMAX = (longint'(1) << (IFM_BIT - 1)) - 1;
`ifdef ACT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] act;
    logic          sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               clear = 1'b0;
  logic [NP*OFM_BIT-1:0] OFM = '0;
  logic               out_valid;
  logic [AW-1:0]      ACTIVATION;
  logic               sat;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  exp_t          sb[$];
  longint        lane_val [NP];
  logic [IFM_BIT-1:0] m_pix [NP][PIX];
  int            m_cnt = 0;
  bit            m_sticky = 1'b0;
  logic [AW-1:0] m_last_act = '0;
  int            pulses = 0;

  activation_window #(
    .OFM_BIT(OFM_BIT), .IFM_BIT(IFM_BIT), .SIZE(SIZE),
    .NUM_POOLING(NP), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clear(clear), .OFM(OFM),
    .out_valid(out_valid), .ACTIVATION(ACTIVATION), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ReLU, shift (optionally rounded), clamp to the positive pixel range.
  function automatic longint quant(input longint x, output bit s);
    longint y;
    s = 1'b0;
    if (x < 0) return 0;
    y = ROUND ? (x + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT)
              : x / (longint'(1) << SHIFT);
    if (y > PMAX) begin
      s = 1'b1;
      return PMAX;
    end
    return y;
  endfunction

  // One clock of stimulus; the model advances by the same clock.
  task automatic step(input bit v, input bit c);
    bit s;
    longint p;
    logic [AW-1:0] w;
    @(negedge clk);
    in_valid = v;
    clear    = c;
    for (int k = 0; k < NP; k++) begin
      logic [63:0] tmp;
      tmp = lane_val[k];
      OFM[k*OFM_BIT +: OFM_BIT] = tmp[OFM_BIT-1:0];
    end
    if (c) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else if (v) begin
      for (int k = 0; k < NP; k++) begin
        p = quant(lane_val[k], s);
        m_pix[k][m_cnt] = IFM_BIT'(p);
        m_sticky |= s;
      end
      m_cnt++;
      if (m_cnt == PIX) begin
        w = '0;
        for (int k = 0; k < NP; k++)
          for (int j = 0; j < PIX; j++)
            w[(k*PIX + j)*IFM_BIT +: IFM_BIT] = m_pix[k][j];
        sb.push_back('{act: w, sat: m_sticky});
        m_cnt    = 0;
        m_sticky = 1'b0;
      end
    end
  endtask

  task automatic set_all(input longint v);
    for (int k = 0; k < NP; k++) lane_val[k] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    m_cnt    = 0;
    m_sticky = 1'b0;
    m_last_act = '0;
    sb.delete();
    #1;
    chk("reset_out_valid", AW'(out_valid), '0);
    chk("reset_activation", ACTIVATION, '0);
    chk("reset_sat", AW'(sat), '0);
    chk("reset_busy", AW'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle, compare against the scoreboard or the held state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("busy", AW'(busy), AW'(m_cnt != 0));
      if (out_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", AW'(out_valid), '0);
        end else begin
          e = sb.pop_front();
          chk("activation", ACTIVATION, e.act);
          chk("sat", AW'(sat), AW'(e.sat));
          m_last_act = e.act;
        end
      end else begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("missing_out_valid", AW'(out_valid), 1);
          m_last_act = e.act;
        end
        chk("activation_hold", ACTIVATION, m_last_act);
        chk("sat_idle", AW'(sat), '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    set_all(0);
    do_reset();

    // Four increasing beats: pixels 5,6,7,8 on every lane.
    set_all(20480); step(1, 0);
    set_all(24576); step(1, 0);
    set_all(28672); step(1, 0);
    set_all(32768); step(1, 0);
    step(0, 0); step(0, 0);

    // ReLU and saturation lanes, then a clean window.
    set_all(4096); lane_val[0] = -1000; lane_val[1] = 1048576;
    repeat (4) step(1, 0);
    set_all(4096);
    repeat (4) step(1, 0);
    step(0, 0);

    // Half-way value: truncation vs rounding.
    set_all(22528);
    repeat (4) step(1, 0);
    step(0, 0);

    // Abort with clear, then a fresh window of pixels 2.
    set_all(8192);
    p0 = pulses;
    step(1, 0); step(1, 0); step(1, 1);
    repeat (4) step(1, 0);
    step(0, 0); step(0, 0);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL clear_pulse_count: got %0d expected 1", pulses - p0);
    end

    // Two windows with a 3-cycle gap inside the first.
    set_all(12288); step(1, 0); step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    set_all(16384); step(1, 0); step(1, 0);
    set_all(40960); repeat (4) step(1, 0);
    step(0, 0); step(0, 0);

    // Reset mid-window, then a full window.
    set_all(90000); repeat (3) step(1, 0);
    do_reset();
    set_all(36864); repeat (4) step(1, 0);
    step(0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NP; k++) begin
        case ($urandom_range(0, 3))
          0: lane_val[k] = -longint'($urandom_range(1, 1 << 27));
          1: lane_val[k] = longint'($urandom_range(0, 600000));
          2: lane_val[k] = longint'($urandom_range(0, (1 << 28) - 1));
          default: lane_val[k] = longint'($urandom_range(518000, 524000));
        endcase
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    step(0, 0); step(0, 0); step(0, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
